// File: rtl/norm_round_pack.sv
// norm_round_pack -- back end of the div/sqrt unit.
// Stage 1 normalizes the raw quotient/root mantissa (one-bit left fix-up,
// denormalizing right shift with sticky collection) and resolves special
// operands. Stage 2 rounds in one of five IEEE modes, detects overflow and
// underflow, and packs the IEEE result with {NV,DZ,OF,UF,NX}.
// Two-stage valid/ready pipeline, one beat per cycle, order preserved.
// Optional feature: define NORM_ROUND_PACK_FTZ_EN to flush tiny results
// to signed zero (flags UF|NX); otherwise gradual underflow is produced.
module norm_round_pack #(
    parameter int C_OP   = 32,
    parameter int C_EXP  = 8,
    parameter int C_MANT = 23,
    parameter int C_RM   = 3
) (
    input  logic              Clk_CI,
    input  logic              Rst_RI,
    input  logic              In_valid_SI,
    output logic              In_ready_SO,
    input  logic              Div_SI,
    input  logic [C_RM-1:0]   RM_SI,
    input  logic              Sign_z_DI,
    input  logic [C_EXP+1:0]  Exp_z_DI,
    input  logic [C_MANT+3:0] Mant_z_DI,
    input  logic              Sticky_SI,
    input  logic              Zero_a_SI,
    input  logic              Zero_b_SI,
    input  logic              Inf_a_SI,
    input  logic              Inf_b_SI,
    input  logic              NaN_a_SI,
    input  logic              NaN_b_SI,
    output logic              Out_valid_SO,
    input  logic              Out_ready_SI,
    output logic [C_OP-1:0]   Result_DO,
    output logic [4:0]        Fflags_SO
);

    localparam int W    = C_MANT + 4;        // raw mantissa width
    localparam int EW   = C_EXP + 2;         // incoming exponent width
    localparam int IW   = C_EXP + 3;         // internal exponent, room for exp-1
    localparam int SHW  = $clog2(W + 1);     // denormalizing shift amount width
    localparam int EMAX = (1 << C_EXP) - 1;  // all-ones exponent (Inf/NaN)

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam logic [4:0] FL_NV = 5'b10000;
    localparam logic [4:0] FL_DZ = 5'b01000;
    localparam logic [4:0] FL_OF = 5'b00100;
    localparam logic [4:0] FL_UF = 5'b00010;
    localparam logic [4:0] FL_NX = 5'b00001;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_v1;
    logic r_v2;
    logic w_adv1;
    logic w_adv2;
    logic w_acc;

    assign w_adv2       = ~r_v2 | Out_ready_SI;
    assign w_adv1       = r_v1 & w_adv2;
    assign In_ready_SO  = ~r_v1 | w_adv2;
    assign w_acc        = In_valid_SI & In_ready_SO;
    assign Out_valid_SO = r_v2;

    // ------------------------------------------------------------------
    // Stage 1: normalize / denormalize
    // ------------------------------------------------------------------
    logic [W-1:0]    w_mant_n;
    logic [IW-1:0]   w_exp_in;
    logic [IW-1:0]   w_exp_n;
    logic            w_tiny;
    logic [IW-1:0]   w_shamt_full;
    logic [SHW-1:0]  w_shamt;
    logic [W-1:0]    w_mant_d;
    logic            w_lost;
    logic [W-1:0]    w_m2;
    logic            w_stk;
    logic [EW-1:0]   w_exp_f;
    logic [2:0]      w_rm;

    assign w_exp_in = {Exp_z_DI[EW-1], Exp_z_DI};

    // Leading one sits at the top bit or one below; fix up the latter.
    always_comb begin
        if (Mant_z_DI[W-1]) begin
            w_mant_n = Mant_z_DI;
            w_exp_n  = w_exp_in;
        end else begin
            w_mant_n = Mant_z_DI << 1;
            w_exp_n  = w_exp_in - IW'(1);
        end
    end

    // Exponent <= 0 means the value is below the smallest normal: shift the
    // mantissa right by 1-exp so it lines up with the subnormal encoding.
    assign w_tiny       = w_exp_n[IW-1] | (w_exp_n == '0);
    assign w_shamt_full = IW'(1) - w_exp_n;
    assign w_shamt      = (w_shamt_full > IW'(W)) ? SHW'(W) : w_shamt_full[SHW-1:0];
    assign w_mant_d     = w_mant_n >> w_shamt;
    assign w_lost       = |(w_mant_n & ~({W{1'b1}} << w_shamt));
    assign w_m2         = w_tiny ? w_mant_d : w_mant_n;
    assign w_stk        = (|w_m2[1:0]) | Sticky_SI | (w_tiny & w_lost);
    // No hidden bit after the shift means an exponent field of zero.
    assign w_exp_f      = w_m2[W-1] ? w_exp_n[EW-1:0] : '0;

    // Collapse the rounding mode; unknown encodings behave as RNE.
    always_comb begin
        w_rm = RM_RNE;
        if (RM_SI == C_RM'(RM_RTZ))      w_rm = RM_RTZ;
        else if (RM_SI == C_RM'(RM_RDN)) w_rm = RM_RDN;
        else if (RM_SI == C_RM'(RM_RUP)) w_rm = RM_RUP;
        else if (RM_SI == C_RM'(RM_RMM)) w_rm = RM_RMM;
    end

    // ------------------------------------------------------------------
    // Stage 1: special operands (bypass rounding entirely)
    // ------------------------------------------------------------------
    logic            w_spec;
    logic [C_OP-1:0] w_spec_res;
    logic [4:0]      w_spec_flg;
    logic [C_OP-1:0] w_qnan;
    logic [C_OP-1:0] w_inf_z;
    logic [C_OP-1:0] w_zero_z;

    assign w_qnan   = {1'b0, {C_EXP{1'b1}}, 1'b1, {(C_MANT-1){1'b0}}};
    assign w_inf_z  = {Sign_z_DI, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
    assign w_zero_z = {Sign_z_DI, {(C_OP-1){1'b0}}};

    // Priority: NaN first, then invalid combinations, then Inf/zero results.
    always_comb begin
        w_spec     = 1'b0;
        w_spec_res = '0;
        w_spec_flg = '0;
        if (NaN_a_SI | NaN_b_SI) begin
            w_spec = 1'b1; w_spec_res = w_qnan; w_spec_flg = FL_NV;
        end else if (Div_SI) begin
            if ((Zero_a_SI & Zero_b_SI) | (Inf_a_SI & Inf_b_SI)) begin
                w_spec = 1'b1; w_spec_res = w_qnan; w_spec_flg = FL_NV;
            end else if (Inf_a_SI) begin
                w_spec = 1'b1; w_spec_res = w_inf_z;
            end else if (Zero_b_SI) begin
                w_spec = 1'b1; w_spec_res = w_inf_z; w_spec_flg = FL_DZ;
            end else if (Inf_b_SI | Zero_a_SI) begin
                w_spec = 1'b1; w_spec_res = w_zero_z;
            end
        end else begin
            if (Zero_a_SI) begin
                w_spec = 1'b1; w_spec_res = w_zero_z;
            end else if (Sign_z_DI) begin
                w_spec = 1'b1; w_spec_res = w_qnan; w_spec_flg = FL_NV;
            end else if (Inf_a_SI) begin
                w_spec = 1'b1; w_spec_res = w_inf_z;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic              r1_sign;
    logic [EW-1:0]     r1_exp;
    logic [C_MANT-1:0] r1_frac;
    logic              r1_guard;
    logic              r1_sticky;
    logic              r1_tiny;
    logic [2:0]        r1_rm;
    logic              r1_spec;
    logic [C_OP-1:0]   r1_spec_res;
    logic [4:0]        r1_spec_flg;

    // Stage 1 valid: refill whenever the slot is free or draining.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI)           r_v1 <= 1'b0;
        else if (In_ready_SO) r_v1 <= In_valid_SI;
    end

    // Stage 1 payload captured on every accepted beat.
    always_ff @(posedge Clk_CI) begin
        if (w_acc) begin
            r1_sign     <= Sign_z_DI;
            r1_exp      <= w_exp_f;
            r1_frac     <= w_m2[W-2:3];
            r1_guard    <= w_m2[2];
            r1_sticky   <= w_stk;
            r1_tiny     <= w_tiny;
            r1_rm       <= w_rm;
            r1_spec     <= w_spec;
            r1_spec_res <= w_spec_res;
            r1_spec_flg <= w_spec_flg;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round and pack
    // ------------------------------------------------------------------
    logic                 w_inc;
    logic                 w_nx;
    logic [EW+C_MANT-1:0] w_sum;
    logic [EW-1:0]        w_rexp;
    logic [C_MANT-1:0]    w_rfrac;
    logic                 w_of;
    logic                 w_ovf_inf;
    logic [C_OP-1:0]      w_res;
    logic [4:0]           w_flg;

    assign w_nx = r1_guard | r1_sticky;

    // Round-up decision per mode.
    always_comb begin
        case (r1_rm)
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = r1_sign & w_nx;
            RM_RUP:  w_inc = ~r1_sign & w_nx;
            RM_RMM:  w_inc = r1_guard;
            default: w_inc = r1_guard & (r1_sticky | r1_frac[0]);
        endcase
    end

    // Rounding on {exp,frac} lets a carry promote subnormal->normal and
    // 1.11..1 -> next binade without extra logic.
    assign w_sum   = {r1_exp, r1_frac} + {{(EW+C_MANT-1){1'b0}}, w_inc};
    assign w_rexp  = w_sum[EW+C_MANT-1:C_MANT];
    assign w_rfrac = w_sum[C_MANT-1:0];
    assign w_of    = (r1_exp >= EW'(EMAX)) | (w_rexp >= EW'(EMAX));

    // Overflow goes to Inf only when the mode rounds away from zero for this sign.
    assign w_ovf_inf = (r1_rm == RM_RNE) | (r1_rm == RM_RMM) |
                       ((r1_rm == RM_RUP) & ~r1_sign) | ((r1_rm == RM_RDN) & r1_sign);

    // Final result select: specials, overflow, (optional flush), normal pack.
    always_comb begin
        w_res = {r1_sign, w_rexp[C_EXP-1:0], w_rfrac};
        w_flg = (r1_tiny & w_nx) ? (FL_UF | FL_NX) : (w_nx ? FL_NX : 5'b00000);
        if (r1_spec) begin
            w_res = r1_spec_res;
            w_flg = r1_spec_flg;
        end else if (w_of) begin
            w_res = w_ovf_inf ? {r1_sign, {C_EXP{1'b1}}, {C_MANT{1'b0}}}
                              : {r1_sign, {(C_EXP-1){1'b1}}, 1'b0, {C_MANT{1'b1}}};
            w_flg = FL_OF | FL_NX;
        end
`ifdef NORM_ROUND_PACK_FTZ_EN
        else if (r1_tiny) begin
            w_res = {r1_sign, {(C_OP-1){1'b0}}};
            w_flg = FL_UF | FL_NX;
        end
`else
`endif
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (drive the outputs directly)
    // ------------------------------------------------------------------
    logic [C_OP-1:0] r_result;
    logic [4:0]      r_fflags;

    // Output stage: holds while stalled, loads when stage 1 advances.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            r_v2     <= 1'b0;
            r_result <= '0;
            r_fflags <= '0;
        end else begin
            if (w_adv2) r_v2 <= r_v1;
            if (w_adv1) begin
                r_result <= w_res;
                r_fflags <= w_flg;
            end
        end
    end

    assign Result_DO = r_result;
    assign Fflags_SO = r_fflags;

endmodule

// File: tb/tb_norm_round_pack.sv
// Bench for norm_round_pack: scoreboard queue filled at drive time, drained
// by a monitor on each output handshake; scenario tasks add inline checks.
module tb_norm_round_pack;

`ifdef NORM_ROUND_PACK_FTZ_EN
    localparam bit FTZ = 1'b1;
`else
    localparam bit FTZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, div, sign, sticky;
    logic [2:0]  rm;
    logic [9:0]  exp_z;
    logic [26:0] mant;
    logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic [4:0]  fflags;

    always #5 clk = ~clk;

    norm_round_pack dut (
        .Clk_CI(clk), .Rst_RI(rst),
        .In_valid_SI(in_valid), .In_ready_SO(in_ready),
        .Div_SI(div), .RM_SI(rm), .Sign_z_DI(sign),
        .Exp_z_DI(exp_z), .Mant_z_DI(mant), .Sticky_SI(sticky),
        .Zero_a_SI(zero_a), .Zero_b_SI(zero_b), .Inf_a_SI(inf_a),
        .Inf_b_SI(inf_b), .NaN_a_SI(nan_a), .NaN_b_SI(nan_b),
        .Out_valid_SO(out_valid), .Out_ready_SI(out_ready),
        .Result_DO(result), .Fflags_SO(fflags)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  flg;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor: a beat leaves when valid&ready at the next posedge.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got %h/%b, nothing expected", result, fflags);
            end else begin
                e = sb_q.pop_front();
                if (result !== e.res || fflags !== e.flg) begin
                    n_fail++;
                    $display("FAIL output: got %h flags %b, expected %h flags %b",
                             result, fflags, e.res, e.flg);
                end
            end
        end
    end

    // Present operands; cls = {Zero_a,Zero_b,Inf_a,Inf_b,NaN_a,NaN_b}.
    task automatic set_beat(input logic d, input logic [2:0] r, input logic s,
                            input logic [9:0] ex, input logic [26:0] mt,
                            input logic st, input logic [5:0] cls,
                            input logic [31:0] eres, input logic [4:0] eflg);
        exp_t e;
        e.res = eres; e.flg = eflg;
        sb_q.push_back(e);
        in_valid = 1'b1; div = d; rm = r; sign = s; exp_z = ex; mant = mt; sticky = st;
        {zero_a, zero_b, inf_a, inf_b, nan_a, nan_b} = cls;
    endtask

    // Drive one beat and wait (bounded) for it to be accepted.
    task automatic send(input logic d, input logic [2:0] r, input logic s,
                        input logic [9:0] ex, input logic [26:0] mt,
                        input logic st, input logic [5:0] cls,
                        input logic [31:0] eres, input logic [4:0] eflg);
        int t;
        set_beat(d, r, s, ex, mt, st, cls, eres, eflg);
        t = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, t);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for the scoreboard to empty; returns beats still pending.
    task automatic wait_drain(output int left);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        left = sb_q.size();
        sb_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        div = 1'b1; rm = 3'd0; sign = 1'b0; exp_z = '0; mant = '0; sticky = 1'b0;
        {zero_a, zero_b, inf_a, inf_b, nan_a, nan_b} = 6'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h, expected 0", result); end
        n_tests++; if (fflags !== 5'h0) begin n_fail++; $display("FAIL reset_fflags: got %b, expected 0", fflags); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int left;
        out_ready = 1'b1;
        set_beat(1'b1, 3'd0, 1'b0, 10'd127, 27'h6000000, 1'b0, 6'b0, 32'h3FC00000, 5'h00);
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b, expected 1", in_ready); end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency1: out_valid %b, expected 0", out_valid); end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency2: out_valid %b, expected 1", out_valid); end
        wait_drain(left);
        n_tests++; if (left !== 0) begin n_fail++; $display("FAIL basic_drain: %0d pending, expected 0", left); end
    endtask

    task automatic test_rounding;
        int left;
        out_ready = 1'b1;
        send(1'b1, 3'd0, 1'b0, 10'd127, 27'h7FFFFFC, 1'b0, 6'b0, 32'h40000000, 5'h01);
        send(1'b1, 3'd1, 1'b0, 10'd127, 27'h7FFFFFC, 1'b0, 6'b0, 32'h3FFFFFFF, 5'h01);
        send(1'b1, 3'd7, 1'b0, 10'd127, 27'h7FFFFFC, 1'b0, 6'b0, 32'h40000000, 5'h01);
        send(1'b1, 3'd2, 1'b1, 10'd127, 27'h4000004, 1'b0, 6'b0, 32'hBF800001, 5'h01);
        send(1'b1, 3'd3, 1'b1, 10'd127, 27'h4000004, 1'b0, 6'b0, 32'hBF800000, 5'h01);
        send(1'b1, 3'd4, 1'b0, 10'd127, 27'h4000004, 1'b0, 6'b0, 32'h3F800001, 5'h01);
        send(1'b1, 3'd0, 1'b0, 10'd127, 27'h4000004, 1'b0, 6'b0, 32'h3F800000, 5'h01);
        send(1'b1, 3'd0, 1'b0, 10'd128, 27'h3000000, 1'b0, 6'b0, 32'h3FC00000, 5'h00);
        wait_drain(left);
        n_tests++; if (left !== 0) begin n_fail++; $display("FAIL rounding_drain: %0d pending, expected 0", left); end
    endtask

    task automatic test_overflow;
        int left;
        out_ready = 1'b1;
        send(1'b1, 3'd0, 1'b0, 10'd255, 27'h4000000, 1'b0, 6'b0, 32'h7F800000, 5'h05);
        send(1'b1, 3'd1, 1'b0, 10'd255, 27'h4000000, 1'b0, 6'b0, 32'h7F7FFFFF, 5'h05);
        send(1'b1, 3'd3, 1'b1, 10'd255, 27'h4000000, 1'b0, 6'b0, 32'hFF7FFFFF, 5'h05);
        send(1'b1, 3'd2, 1'b1, 10'd255, 27'h4000000, 1'b0, 6'b0, 32'hFF800000, 5'h05);
        send(1'b1, 3'd0, 1'b0, 10'd254, 27'h7FFFFFC, 1'b0, 6'b0, 32'h7F800000, 5'h05);
        wait_drain(left);
        n_tests++; if (left !== 0) begin n_fail++; $display("FAIL overflow_drain: %0d pending, expected 0", left); end
    endtask

    task automatic test_underflow;
        int left;
        out_ready = 1'b1;
        send(1'b1, 3'd0, 1'b0, 10'h3FF, 27'h4000000, 1'b0, 6'b0,
             FTZ ? 32'h0 : 32'h00200000, FTZ ? 5'h03 : 5'h00);
        send(1'b1, 3'd0, 1'b0, 10'h3FF, 27'h4000000, 1'b1, 6'b0,
             FTZ ? 32'h0 : 32'h00200000, 5'h03);
        send(1'b1, 3'd0, 1'b0, 10'h000, 27'h7FFFFFF, 1'b0, 6'b0,
             FTZ ? 32'h0 : 32'h00800000, 5'h03);
        send(1'b1, 3'd0, 1'b0, 10'h200, 27'h4000000, 1'b0, 6'b0, 32'h00000000, 5'h03);
        send(1'b1, 3'd3, 1'b0, 10'h200, 27'h4000000, 1'b0, 6'b0,
             FTZ ? 32'h0 : 32'h00000001, 5'h03);
        wait_drain(left);
        n_tests++; if (left !== 0) begin n_fail++; $display("FAIL underflow_drain: %0d pending, expected 0", left); end
    endtask

    task automatic test_specials;
        int left;
        out_ready = 1'b1;
        // Mantissa carries guard/sticky bits to prove specials never raise NX.
        send(1'b1, 3'd0, 1'b1, 10'd127, 27'h4000007, 1'b1, 6'b010000, 32'hFF800000, 5'h08);
        send(1'b0, 3'd0, 1'b1, 10'd127, 27'h4000007, 1'b1, 6'b000000, 32'h7FC00000, 5'h10);
        send(1'b1, 3'd0, 1'b1, 10'd127, 27'h4000007, 1'b1, 6'b000010, 32'h7FC00000, 5'h10);
        send(1'b1, 3'd0, 1'b0, 10'd127, 27'h4000007, 1'b1, 6'b110000, 32'h7FC00000, 5'h10);
        send(1'b1, 3'd0, 1'b1, 10'd127, 27'h4000007, 1'b1, 6'b001000, 32'hFF800000, 5'h00);
        send(1'b1, 3'd0, 1'b0, 10'd127, 27'h4000007, 1'b1, 6'b000100, 32'h00000000, 5'h00);
        send(1'b0, 3'd0, 1'b1, 10'd127, 27'h4000007, 1'b1, 6'b100000, 32'h80000000, 5'h00);
        send(1'b0, 3'd0, 1'b0, 10'd127, 27'h4000007, 1'b1, 6'b001000, 32'h7F800000, 5'h00);
        send(1'b0, 3'd0, 1'b1, 10'd127, 27'h4000007, 1'b1, 6'b001000, 32'h7FC00000, 5'h10);
        wait_drain(left);
        n_tests++; if (left !== 0) begin n_fail++; $display("FAIL specials_drain: %0d pending, expected 0", left); end
    endtask

    task automatic test_back_to_back;
        int left, t;
        logic [31:0] held;
        out_ready = 1'b0;
        set_beat(1'b1, 3'd0, 1'b0, 10'd127, 27'h4000000, 1'b0, 6'b0, 32'h3F800000, 5'h00);
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_a: got %b, expected 1", in_ready); end
        @(posedge clk); #1;
        set_beat(1'b1, 3'd0, 1'b0, 10'd128, 27'h4000000, 1'b0, 6'b0, 32'h40000000, 5'h00);
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_b: got %b, expected 1", in_ready); end
        @(posedge clk); #1;
        set_beat(1'b1, 3'd0, 1'b0, 10'd129, 27'h6000000, 1'b0, 6'b0, 32'h40C00000, 5'h00);
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: in_ready %b, expected 0", in_ready); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: out_valid %b, expected 1", out_valid); end
        held = result;
        @(posedge clk); @(negedge clk);
        n_tests++; if (result !== held || result !== 32'h3F800000) begin
            n_fail++; $display("FAIL b2b_hold: result %h, expected stable 3f800000", result);
        end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall2: in_ready %b, expected 0", in_ready); end
        @(posedge clk); #1 out_ready = 1'b1;
        t = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_resume: in_ready %b, expected 1", in_ready); end
        @(posedge clk); #1 in_valid = 1'b0;
        wait_drain(left);
        n_tests++; if (left !== 0) begin n_fail++; $display("FAIL b2b_drain: %0d pending, expected 0", left); end
    endtask

    task automatic test_reset_mid;
        int left;
        out_ready = 1'b1;
        send(1'b1, 3'd0, 1'b0, 10'd127, 27'h4000000, 1'b0, 6'b0, 32'h3F800000, 5'h00);
        send(1'b1, 3'd0, 1'b0, 10'd128, 27'h4000000, 1'b0, 6'b0, 32'h40000000, 5'h00);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, expected 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b, expected 1", in_ready); end
        n_tests++; if (result !== 32'h0 || fflags !== 5'h0) begin
            n_fail++; $display("FAIL midrst_out: got %h/%b, expected 0/0", result, fflags);
        end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flushed: got %b, expected 0", out_valid); end
        @(posedge clk); #1;
        send(1'b1, 3'd0, 1'b1, 10'd129, 27'h6000000, 1'b0, 6'b0, 32'hC0C00000, 5'h00);
        wait_drain(left);
        n_tests++; if (left !== 0) begin n_fail++; $display("FAIL midrst_drain: %0d pending, expected 0", left); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_overflow();
        test_underflow();
        test_specials();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
